// File: rtl/riscv_imem_line_responder_if.sv
// Line-fetch bus shared by the L0 fetch buffer (upstream), the line responder
// and the word-wide instruction memory (downstream).
// Handshake rules, identical on both sides: a request (instr_req_i / mem_req_o)
// is accepted on the rising clock edge of a cycle in which its grant
// (instr_gnt_o / mem_gnt_i) is also high. An ungranted request keeps its
// address stable. Read data returns in request order as a one-cycle rvalid
// strobe, at the earliest in the cycle after its own grant.
interface riscv_imem_line_responder_if #(
  parameter int RDATA_OUT_WIDTH = 128
);
  logic                       instr_req_i;
  logic [31:0]                instr_addr_i;
  logic                       instr_gnt_o;
  logic                       instr_rvalid_o;
  logic [RDATA_OUT_WIDTH-1:0] instr_rdata_o;
  logic                       mem_req_o;
  logic [31:0]                mem_addr_o;
  logic                       mem_gnt_i;
  logic                       mem_rvalid_i;
  logic [31:0]                mem_rdata_i;

  // Responder side.
  modport slave (
    input  instr_req_i, instr_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, mem_req_o, mem_addr_o
  );

  // Environment side: fetch buffer plus instruction memory.
  modport master (
    output instr_req_i, instr_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/riscv_imem_line_responder.sv
// Memory-side responder for the L0 fetch buffer. Queues line requests in
// order, fetches each line as WORDS sequential 32b reads downstream and
// returns the assembled line with a single instr_rvalid_o pulse.
// state_o exposes the FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 RESP).
module riscv_imem_line_responder #(
  parameter int RDATA_OUT_WIDTH = 128,
  parameter int REQ_Q_DEPTH     = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  riscv_imem_line_responder_if.slave        bus,
  output logic                              busy_o,
  output logic                              stray_rvalid_o,
  output logic [1:0]                        state_o
);
  localparam int WORDS = RDATA_OUT_WIDTH / 32;
  localparam int WB    = $clog2(WORDS);
  localparam int CW    = WB + 1;
  localparam int LW    = 32 - WB - 2;
  localparam int PW    = (REQ_Q_DEPTH > 1) ? $clog2(REQ_Q_DEPTH) : 1;
  localparam int NW    = $clog2(REQ_Q_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Request queue: only the line address bits are stored.
  logic [LW-1:0]             q_addr_q [0:REQ_Q_DEPTH-1];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]             cnt_q, cnt_d, stored_after;
  logic                      q_full, push, pop;
  logic [LW-1:0]             in_line, head_sel;

  // Line fetch state.
  state_t                    state_q, state_d;
  logic [CW-1:0]             iss_cnt_q, iss_cnt_d, rcv_cnt_q, rcv_cnt_d;
  logic [LW-1:0]             head_q, head_d;
  logic [WORDS-1:0][31:0]    line_q, line_d;
  logic                      rcv_ok, start;

  // Registered outputs.
  logic                       mem_req_q, mem_req_d;
  logic [31:0]                mem_addr_q, mem_addr_d;
  logic                       rvalid_q, rvalid_d;
  logic [RDATA_OUT_WIDTH-1:0] rdata_q, rdata_d;
  logic                       stray_q, stray_d;

  // Offset bits of the request address carry no information for a line fetch.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.instr_addr_i[WB+1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (REQ_Q_DEPTH == 1) return '0;
    return p + PW'(1);
  endfunction

  // Grant is withheld while reset is held so every output reads 0 in reset.
  assign q_full  = (cnt_q == NW'(REQ_Q_DEPTH));
  assign push    = bus.instr_req_i && !q_full && !rst;
  assign pop     = (state_q == S_RESP);
  assign in_line = bus.instr_addr_i[31:WB+2];

  assign bus.instr_gnt_o    = !q_full && !rst;
  assign bus.instr_rvalid_o = rvalid_q;
  assign bus.instr_rdata_o  = rdata_q;
  assign bus.mem_req_o      = mem_req_q;
  assign bus.mem_addr_o     = mem_addr_q;
  assign stray_rvalid_o     = stray_q;
  assign busy_o             = (cnt_q != '0) || (state_q != S_IDLE);
  assign state_o            = state_q;

  // Queue bookkeeping and next-state / next-output computation.
  always_comb begin
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d        = cnt_q + NW'(push) - NW'(pop);
    stored_after = cnt_q - NW'(pop);
    // Head of the queue as seen after this cycle: a stored entry if one is
    // left, otherwise the request being accepted right now.
    head_sel     = (stored_after != '0) ? q_addr_q[rd_ptr_d] : in_line;

    // A beat is only accepted when one has been granted and not yet returned.
    rcv_ok = bus.mem_rvalid_i && ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
             (rcv_cnt_q != iss_cnt_q);

    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    rcv_cnt_d = rcv_cnt_q + CW'(rcv_ok);
    head_d    = head_q;
    start     = 1'b0;
    line_d    = line_q;
    if (rcv_ok) line_d[rcv_cnt_q[WB-1:0]] = bus.mem_rdata_i;

    case (state_q)
      S_IDLE:  if (cnt_d != '0) start = 1'b1;
      S_ISSUE: begin
        if (bus.mem_gnt_i) begin
          iss_cnt_d = iss_cnt_q + CW'(1);
          if (iss_cnt_q == CW'(WORDS - 1)) state_d = S_DRAIN;
        end
      end
      // Lookahead on the incoming beat lets RESP follow the last rvalid directly.
      S_DRAIN: if (rcv_cnt_d == CW'(WORDS)) state_d = S_RESP;
      S_RESP:  if (cnt_d != '0) start = 1'b1; else state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d   = S_ISSUE;
      iss_cnt_d = '0;
      rcv_cnt_d = '0;
      head_d    = head_sel;
    end

    mem_req_d  = (state_d == S_ISSUE);
    mem_addr_d = mem_addr_q;
    if (state_d == S_ISSUE) mem_addr_d = {head_d, iss_cnt_d[WB-1:0], 2'b00};
    rvalid_d   = (state_d == S_RESP);
    rdata_d    = (state_d == S_RESP) ? RDATA_OUT_WIDTH'(line_d) : rdata_q;
    stray_d    = bus.mem_rvalid_i && !rcv_ok;
  end

  // Request queue storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REQ_Q_DEPTH; i++) q_addr_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) q_addr_q[wr_ptr_q] <= in_line;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Line-fetch FSM with its counters, line buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iss_cnt_q  <= '0;
      rcv_cnt_q  <= '0;
      head_q     <= '0;
      line_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      head_q     <= head_d;
      line_q     <= line_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      stray_q    <= stray_d;
    end
  end
endmodule

// File: tb/tb_riscv_imem_line_responder.sv
// Self-checking bench for riscv_imem_line_responder (128b lines, 2-deep queue).
module tb_riscv_imem_line_responder;
  localparam int W = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_imem_line_responder_if #(.RDATA_OUT_WIDTH(W)) bus ();
  logic       busy, stray;
  logic [1:0] state;

  riscv_imem_line_responder #(.RDATA_OUT_WIDTH(W), .REQ_Q_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy_o(busy), .stray_rvalid_o(stray), .state_o(state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [31:0]   exp_addr_q[$];
  int            resp_cyc_q[$];
  int            stray_cyc_q[$];

  function automatic logic [W-1:0] line_of(input logic [31:0] a);
    logic [W-1:0] l;
    logic [31:0]  base;
    base = {a[31:4], 4'h0};
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = base + 32'(4 * i);
    return l;
  endfunction

  // ---------------- memory model (word = address) ----------------
  int          mem_lat    = 1;
  logic [31:0] stall_addr = 32'h0;
  int          stall_left = 0;
  int          pend_due[$];
  logic [31:0] pend_data[$];

  always @(negedge clk) begin
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = pend_data.pop_front();
      void'(pend_due.pop_front());
    end else begin
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = $urandom;
    end
    if (bus.mem_req_o && stall_left > 0 && bus.mem_addr_o == stall_addr) begin
      bus.mem_gnt_i = 1'b0;
      stall_left--;
    end else begin
      bus.mem_gnt_i = 1'b1;
    end
    if (bus.mem_req_o && bus.mem_gnt_i) begin
      pend_due.push_back(cyc + mem_lat);
      pend_data.push_back(bus.mem_addr_o);
    end
  end

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = 32'h0;

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (prev_stall) begin
        check("mem_req_held", W'(bus.mem_req_o), W'(1'b1));
        check("mem_addr_held", W'(bus.mem_addr_o), W'(prev_addr));
      end
      prev_stall = bus.mem_req_o && !bus.mem_gnt_i;
      prev_addr  = bus.mem_addr_o;
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        if (exp_addr_q.size() == 0) fail_now("mem_grant_unexpected");
        else check("mem_addr", W'(bus.mem_addr_o), W'(exp_addr_q.pop_front()));
      end
      if (bus.instr_rvalid_o) begin
        resp_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) fail_now("instr_rvalid_unexpected");
        else check("line_data", bus.instr_rdata_o, exp_q.pop_front());
      end
      if (stray) stray_cyc_q.push_back(cyc);
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called right after a falling edge; returns right after a falling edge.
  task automatic send_req(input logic [31:0] a, output int rq, output int g);
    int budget;
    budget = 100;
    rq = cyc;
    g  = -1;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = a;
    while (!bus.instr_gnt_o && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      fail_now("instr_gnt_timeout");
    end else begin
      g = cyc;
      exp_q.push_back(line_of(a));
      for (int i = 0; i < 4; i++) exp_addr_q.push_back({a[31:4], 4'h0} + 32'(4 * i));
    end
    @(negedge clk);
    bus.instr_req_i = 1'b0;
  endtask

  task automatic wait_resp(output int rc);
    int budget;
    budget = 200;
    while (resp_cyc_q.size() == 0 && budget > 0) begin
      @(negedge clk);
      #2;
      budget--;
    end
    if (resp_cyc_q.size() == 0) begin
      fail_now("instr_rvalid_timeout");
      rc = -1;
    end else begin
      rc = resp_cyc_q.pop_front();
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 200;
    while ((busy || exp_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      #2;
      budget--;
    end
    if (budget == 0) fail_now("idle_timeout");
    @(negedge clk);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          stall_beat;
    int          stall_cyc;
    int          exp_lat;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int rq, g, g0, g1, g2, rc;

    vecs[0] = '{32'h0000_1004, 1, 0, 0, 6};   // ideal memory
    vecs[1] = '{32'h0000_2000, 5, 0, 0, 10};  // long read latency, beats drain
    vecs[2] = '{32'h0000_3000, 1, 2, 3, 9};   // grant withheld 3 cycles on beat 2
    vecs[3] = '{32'h0000_400C, 2, 0, 0, 7};   // offset bits ignored
    vecs[4] = '{32'hFFFF_FFF8, 3, 3, 1, 9};   // top of address space, stall last beat
    vecs[5] = '{32'h0000_0500, 1, 0, 2, 8};   // stall on first beat

    rst = 1'b1;
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    repeat (3) @(negedge clk);

    check("rst_gnt",       W'(bus.instr_gnt_o),    '0);
    check("rst_rvalid",    W'(bus.instr_rvalid_o), '0);
    check("rst_rdata",     bus.instr_rdata_o,      '0);
    check("rst_mem_req",   W'(bus.mem_req_o),      '0);
    check("rst_mem_addr",  W'(bus.mem_addr_o),     '0);
    check("rst_busy",      W'(busy),               '0);
    check("rst_stray",     W'(stray),              '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_gnt",   W'(bus.instr_gnt_o), W'(1'b1));
    check("post_rst_state", W'(state),           W'(2'd0));

    // Single requests against differently behaved memories.
    for (int v = 0; v < 6; v++) begin
      mem_lat    = vecs[v].lat;
      stall_addr = {vecs[v].addr[31:4], 4'h0} + 32'(4 * vecs[v].stall_beat);
      stall_left = vecs[v].stall_cyc;
      send_req(vecs[v].addr, rq, g);
      check("gnt_same_cycle", W'(g), W'(rq));
      wait_resp(rc);
      check("line_latency", W'(rc - g), W'(vecs[v].exp_lat));
      wait_idle();
      stall_left = 0;
    end

    // Three back-to-back requests into a 2-deep queue: third waits for the pop.
    mem_lat = 1;
    send_req(32'h0000_0100, rq, g0);
    send_req(32'h0000_0110, rq, g1);
    check("q_second_gnt", W'(g1 - g0), W'(1));
    send_req(32'h0000_0120, rq, g2);
    check("q_third_gnt_after_resp", W'(g2 - g0), W'(7));
    wait_resp(rc);
    check("q_resp0", W'(rc - g0), W'(6));
    wait_resp(rc);
    check("q_resp1", W'(rc - g0), W'(12));
    wait_resp(rc);
    check("q_resp2", W'(rc - g0), W'(18));
    wait_idle();
    check("no_stray_so_far", W'(stray_cyc_q.size()), W'(0));

    // Reset while draining, after two of four beats have returned.
    mem_lat = 5;
    send_req(32'h0000_0700, rq, g);
    do begin
      @(posedge clk);
      #2;
    end while (cyc < g + 8);
    check("pre_rst_state_drain", W'(state), W'(2'd2));
    check("pre_rst_busy",        W'(busy),  W'(1'b1));
    rst = 1'b1;
    #1;
    check("mid_rst_state",    W'(state),              '0);
    check("mid_rst_busy",     W'(busy),               '0);
    check("mid_rst_mem_req",  W'(bus.mem_req_o),      '0);
    check("mid_rst_mem_addr", W'(bus.mem_addr_o),     '0);
    check("mid_rst_rvalid",   W'(bus.instr_rvalid_o), '0);
    check("mid_rst_rdata",    bus.instr_rdata_o,      '0);
    check("mid_rst_gnt",      W'(bus.instr_gnt_o),    '0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (4) @(negedge clk);
    #2;
    check("stray_count", W'(stray_cyc_q.size()), W'(2));
    if (stray_cyc_q.size() == 2) begin
      check("stray_cyc0", W'(stray_cyc_q[0] - g), W'(9));
      check("stray_cyc1", W'(stray_cyc_q[1] - g), W'(10));
    end
    check("post_rst_no_resp", W'(resp_cyc_q.size()), W'(0));

    // Normal operation resumes after the reset.
    mem_lat = 1;
    send_req(32'h0000_0800, rq, g);
    wait_resp(rc);
    check("after_rst_latency", W'(rc - g), W'(6));
    wait_idle();

    check("sb_lines_drained", W'(exp_q.size()),       W'(0));
    check("sb_addrs_drained", W'(exp_addr_q.size()),  W'(0));
    check("stray_total",      W'(stray_cyc_q.size()), W'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog: run still active, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
